// File: rtl/interrupt_ctrl.sv
// Commit-boundary trap sequencer: arbitrates irq/ecall/ebreak/mret, strobes CSR trap updates, redirects fetch.
// Optional macro INTERRUPT_VECTORED_EN enables vectored interrupt targets when mtvec mode is 2'b01.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module interrupt_ctrl (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mip_external_i,
  input  logic                    mip_timer_i,
  input  logic                    mip_software_i,
  input  logic                    mie_external_i,
  input  logic                    mie_timer_i,
  input  logic                    mie_software_i,
  input  logic                    mstatus_ie_i,
  input  logic [`DATA_WIDTH-1:0]  mtvec_i,
  input  logic [`DATA_WIDTH-1:0]  epc_i,
  input  logic                    inst_valid_i,
  input  logic [`DATA_WIDTH-1:0]  inst_addr_i,
  input  logic                    ecall_i,
  input  logic                    ebreak_i,
  input  logic                    mret_i,
  output logic                    stall_o,
  output logic                    flush_o,
  output logic                    redirect_o,
  output logic [`DATA_WIDTH-1:0]  redirect_pc_o,
  output logic                    interrupt_type_o,
  output logic                    cause_we_o,
  output logic [3:0]              cause_o,
  output logic                    epc_we_o,
  output logic [`DATA_WIDTH-1:0]  epc_o,
  output logic                    mstatus_ie_clear_o,
  output logic                    mstatus_ie_set_o
);

  localparam int unsigned DW = `DATA_WIDTH;
  localparam int unsigned CW = 4;

  localparam logic [CW-1:0] CAUSE_EXT    = 4'd11;
  localparam logic [CW-1:0] CAUSE_SW     = 4'd3;
  localparam logic [CW-1:0] CAUSE_TIMER  = 4'd7;
  localparam logic [CW-1:0] CAUSE_ECALL  = 4'd11;
  localparam logic [CW-1:0] CAUSE_EBREAK = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRAP = 2'd1,
    MRET = 2'd2,
    JUMP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cause_q;
  logic            type_q;
  logic [DW-1:0]   epc_q;
  logic            sel_vec_q;

  logic            irq_ext, irq_sw, irq_timer, irq_any;
  logic            trap_evt, accept;
  logic [CW-1:0]   cause_d;
  logic [DW-1:0]   base_addr, vec_target;
  logic            unused_addr_bits;

  // Event arbitration: any enabled interrupt beats ecall, which beats ebreak, which beats mret
  assign irq_ext   = mstatus_ie_i & mip_external_i & mie_external_i;
  assign irq_sw    = mstatus_ie_i & mip_software_i & mie_software_i;
  assign irq_timer = mstatus_ie_i & mip_timer_i & mie_timer_i;
  assign irq_any   = irq_ext | irq_sw | irq_timer;
  assign trap_evt  = irq_any | ecall_i | ebreak_i;
  assign accept    = (state_q == IDLE) & inst_valid_i & ~rst_i & (trap_evt | mret_i);

  always_comb begin
    cause_d = CAUSE_EBREAK;
    if (irq_ext)        cause_d = CAUSE_EXT;
    else if (irq_sw)    cause_d = CAUSE_SW;
    else if (irq_timer) cause_d = CAUSE_TIMER;
    else if (ecall_i)   cause_d = CAUSE_ECALL;
  end

  assign base_addr = {mtvec_i[DW-1:2], 2'b00};
`ifdef INTERRUPT_VECTORED_EN
  assign vec_target = (type_q && (mtvec_i[1:0] == 2'b01))
                    ? base_addr + DW'({cause_q, 2'b00})
                    : base_addr;
`else
  assign vec_target = base_addr;
`endif
  assign unused_addr_bits = ^{mtvec_i[1:0], inst_addr_i[1:0]};

  // State and latched trap information
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cause_q   <= '0;
      type_q    <= 1'b0;
      epc_q     <= '0;
      sel_vec_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_vec_q <= trap_evt;
        if (trap_evt) begin
          cause_q <= cause_d;
          type_q  <= irq_any;
          epc_q   <= {inst_addr_i[DW-1:2], 2'b00};
        end
      end
    end
  end

  // Next state and sequencing strobes; reset forces every strobe low in the same cycle
  always_comb begin
    state_d            = state_q;
    stall_o            = 1'b0;
    flush_o            = 1'b0;
    redirect_o         = 1'b0;
    redirect_pc_o      = '0;
    cause_we_o         = 1'b0;
    epc_we_o           = 1'b0;
    mstatus_ie_clear_o = 1'b0;
    mstatus_ie_set_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          state_d = trap_evt ? TRAP : MRET;
        end
      end
      TRAP: begin
        stall_o            = 1'b1;
        cause_we_o         = 1'b1;
        epc_we_o           = 1'b1;
        mstatus_ie_clear_o = 1'b1;
        state_d            = JUMP;
      end
      MRET: begin
        stall_o          = 1'b1;
        mstatus_ie_set_o = 1'b1;
        state_d          = JUMP;
      end
      JUMP: begin
        stall_o       = 1'b1;
        flush_o       = 1'b1;
        redirect_o    = 1'b1;
        redirect_pc_o = sel_vec_q ? vec_target : epc_i;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      state_d            = IDLE;
      stall_o            = 1'b0;
      flush_o            = 1'b0;
      redirect_o         = 1'b0;
      redirect_pc_o      = '0;
      cause_we_o         = 1'b0;
      epc_we_o           = 1'b0;
      mstatus_ie_clear_o = 1'b0;
      mstatus_ie_set_o   = 1'b0;
    end
  end

  assign cause_o          = cause_q;
  assign interrupt_type_o = type_q;
  assign epc_o            = epc_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl: table vectors, hand-written corner sequences and a random run,
// all compared against a cycle-phase reference model.
module tb_interrupt_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mip_external_i, mip_timer_i, mip_software_i;
  logic        mie_external_i, mie_timer_i, mie_software_i;
  logic        mstatus_ie_i;
  logic [31:0] mtvec_i, epc_i, inst_addr_i;
  logic        inst_valid_i, ecall_i, ebreak_i, mret_i;
  logic        stall_o, flush_o, redirect_o, interrupt_type_o;
  logic        cause_we_o, epc_we_o, mstatus_ie_clear_o, mstatus_ie_set_o;
  logic [31:0] redirect_pc_o, epc_o;
  logic [3:0]  cause_o;

  always #5 clk_i = ~clk_i;

  interrupt_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mip_external_i(mip_external_i), .mip_timer_i(mip_timer_i), .mip_software_i(mip_software_i),
    .mie_external_i(mie_external_i), .mie_timer_i(mie_timer_i), .mie_software_i(mie_software_i),
    .mstatus_ie_i(mstatus_ie_i), .mtvec_i(mtvec_i), .epc_i(epc_i),
    .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .interrupt_type_o(interrupt_type_o), .cause_we_o(cause_we_o), .cause_o(cause_o),
    .epc_we_o(epc_we_o), .epc_o(epc_o),
    .mstatus_ie_clear_o(mstatus_ie_clear_o), .mstatus_ie_set_o(mstatus_ie_set_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 = free, 1 = CSR-update cycle, 2 = redirect cycle
  int          ph = 0;
  logic        m_trap = 1'b0;
  logic [3:0]  m_cause = 4'd0;
  logic        m_type = 1'b0;
  logic [31:0] m_epc = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] trap_target(input logic [31:0] tv, input logic [3:0] c, input logic t);
    logic [31:0] b;
    logic vec_en;
`ifdef INTERRUPT_VECTORED_EN
    vec_en = 1'b1;
`else
    vec_en = 1'b0;
`endif
    b = tv & 32'hFFFF_FFFC;
    if (vec_en && t && tv[1:0] == 2'b01) b = b + 32'(c) * 32'd4;
    return b;
  endfunction

  // One clock: compare every output at the falling edge, then advance the model at the rising edge
  task automatic step();
    int irq_code;
    logic ev_trap, acc;
    logic e_stall, e_flush, e_red, e_cwe, e_ewe, e_clr, e_set;
    logic [31:0] e_pc;
    @(negedge clk_i);
    irq_code = 0;
    if (mstatus_ie_i) begin
      if (mip_external_i && mie_external_i) irq_code = 11;
      else if (mip_software_i && mie_software_i) irq_code = 3;
      else if (mip_timer_i && mie_timer_i) irq_code = 7;
    end
    ev_trap = (irq_code != 0) || ecall_i || ebreak_i;
    acc = inst_valid_i && (ev_trap || mret_i);
    {e_stall, e_flush, e_red, e_cwe, e_ewe, e_clr, e_set} = '0;
    e_pc = 32'd0;
    if (!rst_i) begin
      if (ph == 0) e_stall = acc;
      else if (ph == 1) begin
        e_stall = 1'b1;
        if (m_trap) {e_cwe, e_ewe, e_clr} = 3'b111;
        else e_set = 1'b1;
      end else begin
        {e_stall, e_flush, e_red} = 3'b111;
        e_pc = m_trap ? trap_target(mtvec_i, m_cause, m_type) : epc_i;
      end
    end
    chk("stall", 32'(stall_o), 32'(e_stall));
    chk("flush", 32'(flush_o), 32'(e_flush));
    chk("redirect", 32'(redirect_o), 32'(e_red));
    chk("redirect_pc", redirect_pc_o, e_pc);
    chk("cause_we", 32'(cause_we_o), 32'(e_cwe));
    chk("epc_we", 32'(epc_we_o), 32'(e_ewe));
    chk("ie_clear", 32'(mstatus_ie_clear_o), 32'(e_clr));
    chk("ie_set", 32'(mstatus_ie_set_o), 32'(e_set));
    chk("cause", 32'(cause_o), 32'(m_cause));
    chk("type", 32'(interrupt_type_o), 32'(m_type));
    chk("epc", epc_o, m_epc);
    @(posedge clk_i);
    if (rst_i) begin
      ph = 0; m_trap = 1'b0; m_cause = 4'd0; m_type = 1'b0; m_epc = 32'd0;
    end else if (ph == 0) begin
      if (acc) begin
        ph = 1;
        m_trap = ev_trap;
        if (ev_trap) begin
          m_type = (irq_code != 0);
          m_cause = (irq_code != 0) ? 4'(irq_code) : (ecall_i ? 4'd11 : 4'd3);
          m_epc = inst_addr_i & 32'hFFFF_FFFC;
        end
      end
    end else if (ph == 1) ph = 2;
    else ph = 0;
    #1;
  endtask

  task automatic clear_events();
    {mip_external_i, mip_timer_i, mip_software_i} = '0;
    {mie_external_i, mie_timer_i, mie_software_i} = '0;
    {mstatus_ie_i, inst_valid_i, ecall_i, ebreak_i, mret_i} = '0;
  endtask

  typedef struct {
    logic        ie;
    logic [2:0]  mip;   // {external, software, timer}
    logic [2:0]  mie;
    logic        ecall, ebreak, mret;
    logic [31:0] addr, mtvec, epc;
    logic [3:0]  exp_cause;
    logic        exp_type;
    logic [31:0] exp_epc, exp_pc_vec, exp_pc_base;
  } vec_t;

  vec_t tbl[9];
  logic vec_build;

  initial begin
`ifdef INTERRUPT_VECTORED_EN
    vec_build = 1'b1;
`else
    vec_build = 1'b0;
`endif
    //           ie  mip     mie     ec eb mr addr          mtvec         epc           cause type epc        pc_vec       pc_base
    tbl[0] = '{1'b1, 3'b001, 3'b001, 0, 0, 0, 32'h0000_0104, 32'h0000_0200, 32'h0, 4'd7,  1'b1, 32'h104, 32'h200, 32'h200};
    tbl[1] = '{1'b1, 3'b101, 3'b111, 0, 0, 0, 32'h0000_0040, 32'h0000_0201, 32'h0, 4'd11, 1'b1, 32'h040, 32'h22C, 32'h200};
    tbl[2] = '{1'b0, 3'b001, 3'b001, 1, 0, 0, 32'h0000_0310, 32'h0000_0201, 32'h0, 4'd11, 1'b0, 32'h310, 32'h200, 32'h200};
    tbl[3] = '{1'b1, 3'b000, 3'b111, 0, 1, 0, 32'h0000_0313, 32'h0000_1000, 32'h0, 4'd3,  1'b0, 32'h310, 32'h1000, 32'h1000};
    tbl[4] = '{1'b1, 3'b011, 3'b011, 0, 0, 0, 32'h0000_0500, 32'h0000_0301, 32'h0, 4'd3,  1'b1, 32'h500, 32'h30C, 32'h300};
    tbl[5] = '{1'b1, 3'b000, 3'b111, 0, 0, 1, 32'h0000_0600, 32'h0000_0301, 32'h108, 4'd3, 1'b1, 32'h500, 32'h108, 32'h108};
    tbl[6] = '{1'b1, 3'b100, 3'b100, 0, 0, 1, 32'h0000_0208, 32'h0000_0400, 32'h108, 4'd11, 1'b1, 32'h208, 32'h400, 32'h400};
    tbl[7] = '{1'b1, 3'b000, 3'b000, 1, 1, 0, 32'h0000_0704, 32'h0000_0801, 32'h0, 4'd11, 1'b0, 32'h704, 32'h800, 32'h800};
    tbl[8] = '{1'b1, 3'b001, 3'b001, 0, 0, 0, 32'h0000_0900, 32'h0000_0202, 32'h0, 4'd7,  1'b1, 32'h900, 32'h200, 32'h200};

    clear_events();
    rst_i = 1'b1; mtvec_i = 32'd0; epc_i = 32'd0; inst_addr_i = 32'd0;
    @(posedge clk_i); #1;
    step();
    chk("reset_cause", 32'(cause_o), 32'd0);
    chk("reset_epc", epc_o, 32'd0);
    chk("reset_stall", 32'(stall_o), 32'd0);
    rst_i = 1'b0;
    step();

    // Table vectors: accept, CSR update, redirect, idle
    for (int i = 0; i < 9; i++) begin
      mstatus_ie_i = tbl[i].ie;
      {mip_external_i, mip_software_i, mip_timer_i} = tbl[i].mip;
      {mie_external_i, mie_software_i, mie_timer_i} = tbl[i].mie;
      ecall_i = tbl[i].ecall; ebreak_i = tbl[i].ebreak; mret_i = tbl[i].mret;
      inst_addr_i = tbl[i].addr; mtvec_i = tbl[i].mtvec; epc_i = tbl[i].epc;
      inst_valid_i = 1'b1;
      #1 chk($sformatf("v%0d_accept_stall", i), 32'(stall_o), 32'd1);
      step();
      clear_events();
      #1;
      chk($sformatf("v%0d_cause", i), 32'(cause_o), 32'(tbl[i].exp_cause));
      chk($sformatf("v%0d_type", i), 32'(interrupt_type_o), 32'(tbl[i].exp_type));
      chk($sformatf("v%0d_epc", i), epc_o, tbl[i].exp_epc);
      step();
      chk($sformatf("v%0d_redirect", i), 32'(redirect_o), 32'd1);
      chk($sformatf("v%0d_target", i), redirect_pc_o, vec_build ? tbl[i].exp_pc_vec : tbl[i].exp_pc_base);
      step();
      step();
    end

    // Irq pending while the boundary is empty: no stall until an instruction shows up
    mstatus_ie_i = 1'b1; mip_timer_i = 1'b1; mie_timer_i = 1'b1;
    inst_addr_i = 32'h0000_0A00; mtvec_i = 32'h0000_0200;
    for (int i = 0; i < 3; i++) step();
    chk("novalid_stall", 32'(stall_o), 32'd0);
    inst_valid_i = 1'b1;
    #1 chk("valid_accept_stall", 32'(stall_o), 32'd1);
    step();
    clear_events();
    #1 chk("valid_accept_epc", epc_o, 32'h0000_0A00);
    step(); step(); step();

    // Reset during the CSR-update cycle aborts with no strobe and no redirect
    mstatus_ie_i = 1'b1; mip_timer_i = 1'b1; mie_timer_i = 1'b1;
    inst_addr_i = 32'h0000_0104; inst_valid_i = 1'b1;
    step();
    clear_events();
    rst_i = 1'b1;
    #1 chk("rst_trap_cause_we", 32'(cause_we_o), 32'd0);
    chk("rst_trap_ie_clear", 32'(mstatus_ie_clear_o), 32'd0);
    step();
    rst_i = 1'b0;
    #1 chk("rst_after_redirect", 32'(redirect_o), 32'd0);
    chk("rst_after_cause", 32'(cause_o), 32'd0);
    step(); step();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst_i = ($urandom_range(0, 59) == 0);
      mstatus_ie_i = $urandom_range(0, 1) == 1;
      {mip_external_i, mip_software_i, mip_timer_i} = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      {mie_external_i, mie_software_i, mie_timer_i} = 3'($urandom_range(0, 7));
      ecall_i = ($urandom_range(0, 5) == 0);
      ebreak_i = ($urandom_range(0, 5) == 0);
      mret_i = ($urandom_range(0, 4) == 0);
      inst_valid_i = ($urandom_range(0, 2) != 0);
      inst_addr_i = $urandom;
      mtvec_i = $urandom;
      epc_i = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
